// File: rtl/modbus_pkg.sv
// Shared Modbus RTU definitions: framer state encoding, CRC-16 constants and helper,
// output word bit positions and standard exception codes.
package modbus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StFunc,
        StExc,
        StPayload,
        StCrcLo,
        StCrcHi
    } tx_state_e;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;
    localparam logic [7:0]  EXC_FLAG = 8'h80;

    localparam int unsigned SOF_BIT = 9;
    localparam int unsigned EOF_BIT = 10;

    localparam logic [7:0] EXC_ILLEGAL_FUNCTION    = 8'h01;
    localparam logic [7:0] EXC_ILLEGAL_DATA_ADDR   = 8'h02;
    localparam logic [7:0] EXC_ILLEGAL_DATA_VALUE  = 8'h03;
    localparam logic [7:0] EXC_SLAVE_DEVICE_FAILURE = 8'h04;

    // One byte of the reflected CRC-16, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/modbus_crc16.sv
// Byte-wide single-cycle Modbus CRC-16 accumulator with clear and enable;
// shared by the transmit framer and the receiver.
module modbus_crc16
    import modbus_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_crc <= CRC_INIT;
        end else if (i_clear) begin
            r_crc <= CRC_INIT;
        end else if (i_en) begin
            r_crc <= crc16_byte(r_crc, i_data);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/modbus_response_tx.sv
// Modbus RTU response framer: addr, function, payload or exception code, CRC lo/hi into the
// UART FIFO. Define MODBUS_TX_LENGTH_LIMIT_EN to truncate payloads beyond MAX_PAYLOAD.
module modbus_response_tx
    import modbus_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = 252
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_stationAddr,
    input  logic [7:0]  i_function,
    input  logic        i_exception,
    input  logic [7:0]  i_excCode,
    input  logic [7:0]  i_plData,
    input  logic        i_plValid,
    input  logic        i_plLast,
    output logic        o_plReady,
    input  logic        i_full,
    output logic        o_writeReq,
    output logic [10:0] o_dataOut,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overrun
);

    if (MAX_PAYLOAD < 1 || MAX_PAYLOAD > 255) begin : g_bad_max_payload
        $error("MAX_PAYLOAD must be in 1..255");
    end

    tx_state_e   r_state, w_state_next;
    logic [7:0]  r_addr, r_func, r_exc_code;
    logic        r_exc;
    logic        r_done;
    logic        w_start_ok;
    logic        w_pl_accept;
    logic        w_pl_keep;
    logic        w_write;
    logic        w_crc_en;
    logic        w_pl_ready;
    logic        w_sof, w_eof;
    logic [7:0]  w_byte;
    logic [10:0] w_data;
    logic [15:0] w_crc;

    assign w_start_ok  = (r_state == StIdle) & i_start;
    assign w_pl_accept = (r_state == StPayload) & i_plValid & ~i_full;

`ifdef MODBUS_TX_LENGTH_LIMIT_EN
    localparam logic [8:0] MAX_CNT = 9'(MAX_PAYLOAD);

    logic [7:0] r_count;
    logic       r_overrun;

    assign w_pl_keep = ({1'b0, r_count} < MAX_CNT);

    // Excess bytes are still consumed so the source drains to plLast.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_start_ok) begin
            r_count   <= 8'h00;
            r_overrun <= 1'b0;
        end else if (w_pl_accept) begin
            if (w_pl_keep) begin
                r_count <= r_count + 8'h01;
            end else begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_overrun = r_overrun;
`else
    assign w_pl_keep = 1'b1;
    assign o_overrun = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr     <= 8'h00;
            r_func     <= 8'h00;
            r_exc      <= 1'b0;
            r_exc_code <= 8'h00;
        end else if (w_start_ok) begin
            r_addr     <= i_stationAddr;
            r_func     <= i_function;
            r_exc      <= i_exception;
            r_exc_code <= i_excCode;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == StCrcHi) & w_write;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_write      = 1'b0;
        w_byte       = 8'h00;
        w_sof        = 1'b0;
        w_eof        = 1'b0;
        w_pl_ready   = 1'b0;
        w_crc_en     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) w_state_next = StAddr;
            end
            StAddr: begin
                w_write  = ~i_full;
                w_crc_en = w_write;
                w_byte   = r_addr;
                w_sof    = 1'b1;
                if (w_write) w_state_next = StFunc;
            end
            StFunc: begin
                w_write  = ~i_full;
                w_crc_en = w_write;
                w_byte   = r_exc ? (r_func | EXC_FLAG) : r_func;
                if (w_write) w_state_next = r_exc ? StExc : StPayload;
            end
            StExc: begin
                w_write  = ~i_full;
                w_crc_en = w_write;
                w_byte   = r_exc_code;
                if (w_write) w_state_next = StCrcLo;
            end
            StPayload: begin
                w_pl_ready = ~i_full;
                w_write    = w_pl_accept & w_pl_keep;
                w_crc_en   = w_write;
                w_byte     = i_plData;
                if (w_pl_accept && i_plLast) w_state_next = StCrcLo;
            end
            StCrcLo: begin
                w_write = ~i_full;
                w_byte  = w_crc[7:0];
                if (w_write) w_state_next = StCrcHi;
            end
            StCrcHi: begin
                w_write = ~i_full;
                w_byte  = w_crc[15:8];
                w_eof   = 1'b1;
                if (w_write) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_data          = 11'h000;
        w_data[7:0]     = w_byte;
        w_data[SOF_BIT] = w_sof;
        w_data[EOF_BIT] = w_eof;
    end

    modbus_crc16 u_crc (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clear(w_start_ok),
        .i_en   (w_crc_en),
        .i_data (w_byte),
        .o_crc  (w_crc)
    );

    assign o_writeReq = w_write;
    assign o_dataOut  = w_data;
    assign o_plReady  = w_pl_ready;
    assign o_busy     = (r_state != StIdle);
    assign o_done     = r_done;

endmodule

// File: tb/tb_modbus_response_tx.sv
// Self-checking bench for modbus_response_tx: table of frames, scoreboard of expected FIFO
// words, plus hand-written stall, start-while-busy and mid-frame reset sequences.
module tb_modbus_response_tx;

`ifdef MODBUS_TX_LENGTH_LIMIT_EN
    localparam int TB_MAX = 4;
`else
    localparam int TB_MAX = 252;
`endif

    typedef struct packed {
        logic [7:0]      addr;
        logic [7:0]      fn;
        logic            exc;
        logic [7:0]      exc_code;
        logic [3:0]      n;
        logic [7:0][7:0] pl;
        logic            use_model;
        logic [15:0]     crc;
        logic [1:0]      mode;   // 0 plain, 1 FIFO stalls, 2 payload gaps + start while busy
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [7:0]  i_stationAddr, i_function, i_excCode, i_plData;
    logic        i_exception, i_plValid, i_plLast, i_full;
    logic        o_plReady, o_writeReq, o_busy, o_done, o_overrun;
    logic [10:0] o_dataOut;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [10:0] exp_q[$];
    logic [10:0] mon_word;
    logic [10:0] prev_data;
    bit          prev_stall = 0;
    bit          frame_exc = 0;
    bit          ready_seen = 0;
    vec_t        vecs[8];

    modbus_response_tx #(.MAX_PAYLOAD(TB_MAX)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (i_start),
        .i_stationAddr(i_stationAddr),
        .i_function   (i_function),
        .i_exception  (i_exception),
        .i_excCode    (i_excCode),
        .i_plData     (i_plData),
        .i_plValid    (i_plValid),
        .i_plLast     (i_plLast),
        .o_plReady    (o_plReady),
        .i_full       (i_full),
        .o_writeReq   (o_writeReq),
        .o_dataOut    (o_dataOut),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic push_expected(input vec_t f);
        logic [15:0] crc;
        logic [7:0]  fb;
        int          cnt;
        fb  = f.exc ? (f.fn | 8'h80) : f.fn;
        crc = crc_step(crc_step(16'hFFFF, f.addr), fb);
        exp_q.push_back({3'b010, f.addr});
        exp_q.push_back({3'b000, fb});
        if (f.exc) begin
            exp_q.push_back({3'b000, f.exc_code});
            crc = crc_step(crc, f.exc_code);
        end else begin
            cnt = (int'(f.n) > TB_MAX) ? TB_MAX : int'(f.n);
            for (int i = 0; i < cnt; i++) begin
                exp_q.push_back({3'b000, f.pl[i]});
                crc = crc_step(crc, f.pl[i]);
            end
        end
        if (!f.use_model) crc = f.crc;
        exp_q.push_back({3'b000, crc[7:0]});
        exp_q.push_back({3'b100, crc[15:8]});
    endtask

    // Scoreboard monitor: every FIFO write pops one expected word.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (o_writeReq) begin
                check("no_write_when_full", {31'd0, i_full}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got %0h, expected no write", o_dataOut);
                end else begin
                    mon_word = exp_q.pop_front();
                    check("data_word", {21'd0, o_dataOut}, {21'd0, mon_word});
                end
            end
            if (o_plReady && frame_exc) ready_seen = 1;
            if (prev_stall && i_full && !o_plReady && o_busy)
                check("stall_stable", {21'd0, o_dataOut}, {21'd0, prev_data});
            prev_stall = i_full && !o_plReady && o_busy;
            prev_data  = o_dataOut;
        end
    end

    // Called just after a posedge with the DUT idle; returns just after a posedge.
    task automatic run_frame(input vec_t f, input string tag);
        int idx, k, lat, g;
        g = 0;
        while (o_busy && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        i_start       = 1'b1;
        i_stationAddr = f.addr;
        i_function    = f.fn;
        i_exception   = f.exc;
        i_excCode     = f.exc_code;
        frame_exc     = f.exc;
        ready_seen    = 0;
        push_expected(f);
        @(posedge clk);
        #1;
        i_start       = 1'b0;
        i_stationAddr = 8'hEE;
        i_function    = 8'hEE;
        i_exception   = ~f.exc;
        i_excCode     = 8'hEE;
        idx = 0;
        k   = 0;
        lat = -1;
        while (lat < 0 && k < 200) begin
            i_plValid = !f.exc && (idx < int'(f.n)) && (f.mode != 2'd2 || (k % 2) == 0);
            i_plLast  = (idx == int'(f.n) - 1);
            i_plData  = (idx < 8) ? f.pl[idx] : 8'h00;
            i_full    = (f.mode == 2'd1) && (k inside {1, 2, 3, 9, 10});
            if (f.mode == 2'd2 && k == 3) begin
                i_start       = 1'b1;
                i_stationAddr = 8'h55;
                i_function    = 8'h66;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk);
            if (i_plValid && o_plReady) idx++;
            if (o_done) lat = k;
            @(posedge clk);
            #1;
            k++;
        end
        i_plValid = 1'b0;
        i_plLast  = 1'b0;
        i_full    = 1'b0;
        i_start   = 1'b0;
        if (lat < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done, expected done within 200 cycles", tag);
        end else if (f.mode == 2'd0) begin
            check({tag, "_done_latency"}, lat, f.exc ? 5 : int'(f.n) + 4);
        end
        check({tag, "_payload_consumed"}, idx, f.exc ? 0 : int'(f.n));
        if (f.exc) check({tag, "_plReady_never"}, {31'd0, ready_seen}, 32'd0);
        check({tag, "_overrun"}, {31'd0, o_overrun}, {31'd0, (!f.exc && int'(f.n) > TB_MAX)});
        check({tag, "_busy_after_done"}, {31'd0, o_busy}, 32'd0);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{addr: 8'h01, fn: 8'h03, exc: 1'b0, exc_code: 8'h00, n: 4'd4,
                    pl: 64'h0000_0000_0A00_0000, use_model: 1'b0, crc: 16'hCDC5, mode: 2'd0};
        vecs[1] = '{addr: 8'h01, fn: 8'h03, exc: 1'b1, exc_code: 8'h02, n: 4'd0,
                    pl: 64'h0, use_model: 1'b0, crc: 16'hF1C0, mode: 2'd0};
        vecs[2] = vecs[0];
        vecs[2].mode = 2'd1;
        vecs[3] = vecs[0];
        vecs[3].mode = 2'd2;
        vecs[4] = '{addr: 8'h11, fn: 8'h04, exc: 1'b0, exc_code: 8'h00, n: 4'd1,
                    pl: 64'h5A, use_model: 1'b1, crc: 16'h0, mode: 2'd0};
        vecs[5] = '{addr: 8'hF7, fn: 8'h10, exc: 1'b0, exc_code: 8'h00, n: 4'd8,
                    pl: 64'h0807_0605_0403_0201, use_model: 1'b1, crc: 16'h0, mode: 2'd0};
        vecs[6] = '{addr: 8'h22, fn: 8'h06, exc: 1'b1, exc_code: 8'h04, n: 4'd0,
                    pl: 64'h0, use_model: 1'b1, crc: 16'h0, mode: 2'd1};
        vecs[7] = '{addr: 8'h01, fn: 8'h03, exc: 1'b0, exc_code: 8'h00, n: 4'd6,
                    pl: 64'h0000_6655_4433_2211, use_model: 1'b1, crc: 16'h0, mode: 2'd0};

        rst = 1'b1;
        i_start = 1'b0;
        i_stationAddr = 8'h00;
        i_function = 8'h00;
        i_exception = 1'b0;
        i_excCode = 8'h00;
        i_plData = 8'h00;
        i_plValid = 1'b0;
        i_plLast = 1'b0;
        i_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_writeReq", {31'd0, o_writeReq}, 32'd0);
        check("reset_busy", {31'd0, o_busy}, 32'd0);
        check("reset_done", {31'd0, o_done}, 32'd0);
        check("reset_overrun", {31'd0, o_overrun}, 32'd0);
        check("reset_plReady", {31'd0, o_plReady}, 32'd0);
        check("reset_dataOut", {21'd0, o_dataOut}, 32'd0);
        @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v], $sformatf("vec%0d", v));
        end

        // Mid-frame reset while in payload: partial frame must stop dead.
        i_start       = 1'b1;
        i_stationAddr = 8'h01;
        i_function    = 8'h03;
        i_exception   = 1'b0;
        push_expected(vecs[0]);
        @(posedge clk);
        #1;
        i_start   = 1'b0;
        i_plValid = 1'b1;
        i_plData  = 8'h00;
        i_plLast  = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_writeReq", {31'd0, o_writeReq}, 32'd0);
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        check("abort_done", {31'd0, o_done}, 32'd0);
        @(posedge clk);
        #1;
        i_plValid = 1'b0;
        run_frame(vecs[0], "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
